iir_sos_tdm_filter: RTL and testbench

- Programmable IIR filter: NSEC cascaded second-order sections (Direct Form II), NCH independent channels, one time-multiplexed multiplier.
- Generalises the fixed-coefficient 6th-order Chebyshev band-stop chain. Coefficients are runtime-writable, state is kept per channel, and the block adds a valid/ready input handshake, bypass, saturation and round-to-nearest.
- Sits between the sample source (Q15.13, fs 360 Hz) and downstream processing.

---
 rtl/iir_sos_tdm_filter.sv | 241 ++++++++++++++++++++++++
 tb/tb_iir_sos_tdm_filter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/iir_sos_tdm_filter.sv
// Multi-channel cascade of Direct Form II biquads sharing one multiplier.
// Each sample takes five multiply-accumulate cycles per section (a1, a2, b0, b1, b2).
module iir_sos_tdm_filter #(
   parameter  int WL   = 28,
   parameter  int CWL  = 18,
   parameter  int CFL  = 14,
   parameter  int NSEC = 3,
   parameter  int NCH  = 2,
   localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int AW   = (5 * NSEC > 1) ? $clog2(5 * NSEC) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CHW-1:0]        in_ch,
   input  logic signed [WL-1:0]  x,
   input  logic                  bypass,
   output logic                  out_valid,
   output logic [CHW-1:0]        out_ch,
   output logic signed [WL-1:0]  y,
   input  logic                  coef_we,
   input  logic [AW-1:0]         coef_addr,
   input  logic signed [CWL-1:0] coef_wdata,
   output logic                  coef_wr_err,
   input  logic                  state_clr,
   output logic                  sat_flag,
   input  logic                  sat_clr
);

   localparam int NC   = 5 * NSEC;
   localparam int NS   = NCH * NSEC;
   localparam int SIW  = (NS > 1) ? $clog2(NS) : 1;
   localparam int SW   = (NSEC > 1) ? $clog2(NSEC) : 1;
   localparam int PW   = WL + CWL;
   localparam int ACCW = PW + 3;

   localparam logic [AW:0]   NC_W  = (AW + 1)'(NC);
   localparam logic [CHW:0]  NCH_W = (CHW + 1)'(NCH);
   localparam logic signed [CWL-1:0] COEF_ONE = CWL'(2 ** CFL);
   localparam logic signed [ACCW-1:0] RND  = ACCW'(2 ** (CFL - 1));
   localparam logic signed [ACCW-1:0] MAXV = $signed({{(ACCW - WL + 1){1'b0}}, {(WL - 1){1'b1}}});
   localparam logic signed [ACCW-1:0] MINV = $signed({{(ACCW - WL + 1){1'b1}}, {(WL - 1){1'b0}}});

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t                r_state;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [CHW-1:0]        r_out_ch;
   logic signed [WL-1:0]  r_y;
   logic                  r_coef_wr_err;
   logic                  r_sat_flag;
   logic signed [CWL-1:0] r_coef [NC];
   logic signed [CWL-1:0] r_coef_q;
   logic signed [WL-1:0]  r_w1 [NS];
   logic signed [WL-1:0]  r_w2 [NS];
   logic signed [WL-1:0]  r_s;
   logic signed [WL-1:0]  r_w;
   logic signed [ACCW-1:0] r_acc;
   logic [CHW-1:0]        r_ch;
   logic                  r_byp;
   logic [SW-1:0]         r_sec;
   logic [2:0]            r_step;
   logic                  r_prime;

   logic [SIW-1:0]        w_sidx;
   logic [SW-1:0]         w_nsec;
   logic [2:0]            w_nstep;
   logic                  w_last;
   logic [2:0]            w_cmap;
   logic [AW-1:0]         w_fidx;
   logic signed [WL-1:0]  w_dat;
   logic signed [PW-1:0]  w_prod;
   logic signed [ACCW-1:0] w_prod_ext;
   logic signed [ACCW-1:0] w_s_ext;
   logic signed [ACCW-1:0] w_acc_next;
   logic signed [ACCW-1:0] w_rnd;
   logic signed [ACCW-1:0] w_shr;
   logic                  w_sat_hi;
   logic                  w_sat_lo;
   logic signed [WL-1:0]  w_res;
   logic                  w_sat_evt;
   logic                  w_coef_ok;

   assign w_sidx = SIW'(r_ch * NSEC + r_sec);
   assign w_coef_ok = ({1'b0, coef_addr} < NC_W);

   // Coefficient for the next MAC step is prefetched one cycle ahead (registered read).
   always_comb begin
      w_nsec  = r_sec;
      w_nstep = r_step;
      w_last  = 1'b0;
      if (!r_prime) begin
         if (r_step == 3'd4) begin
            w_nstep = 3'd0;
            if (r_sec == SW'(NSEC - 1)) w_last = 1'b1;
            else                        w_nsec = r_sec + 1'b1;
         end else begin
            w_nstep = r_step + 3'd1;
         end
      end
      unique case (w_nstep)
         3'd0:    w_cmap = 3'd3;
         3'd1:    w_cmap = 3'd4;
         3'd2:    w_cmap = 3'd0;
         3'd3:    w_cmap = 3'd1;
         default: w_cmap = 3'd2;
      endcase
      w_fidx = w_last ? '0 : AW'(w_nsec * 5 + w_cmap);
   end

   always_comb begin
      unique case (r_step)
         3'd0, 3'd3: w_dat = r_w1[w_sidx];
         3'd1, 3'd4: w_dat = r_w2[w_sidx];
         default:    w_dat = r_w;
      endcase
   end

   assign w_prod = $signed({{WL{r_coef_q[CWL-1]}}, r_coef_q}) * $signed({{CWL{w_dat[WL-1]}}, w_dat});
   assign w_prod_ext = $signed({{3{w_prod[PW-1]}}, w_prod});
   assign w_s_ext = $signed({{(ACCW - WL - CFL){r_s[WL-1]}}, r_s, {CFL{1'b0}}});

   always_comb begin
      unique case (r_step)
         3'd0:    w_acc_next = w_s_ext - w_prod_ext;
         3'd1:    w_acc_next = r_acc - w_prod_ext;
         3'd2:    w_acc_next = w_prod_ext;
         default: w_acc_next = r_acc + w_prod_ext;
      endcase
   end

   assign w_rnd    = w_acc_next + RND;
   assign w_shr    = w_rnd >>> CFL;
   assign w_sat_hi = (w_shr > MAXV);
   assign w_sat_lo = (w_shr < MINV);
   assign w_res    = w_sat_hi ? {1'b0, {(WL - 1){1'b1}}} :
                     w_sat_lo ? {1'b1, {(WL - 1){1'b0}}} : w_shr[WL-1:0];
   assign w_sat_evt = (r_state == S_MAC) && !r_prime && !r_byp &&
                      ((r_step == 3'd1) || (r_step == 3'd4)) && (w_sat_hi || w_sat_lo);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NC; i++) r_coef[i] <= ((i % 5) == 0) ? COEF_ONE : '0;
         r_coef_q <= '0;
      end else begin
         if (coef_we && w_coef_ok && (r_state == S_IDLE)) r_coef[coef_addr] <= coef_wdata;
         r_coef_q <= r_coef[w_fidx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_in_ready    <= 1'b1;
         r_out_valid   <= 1'b0;
         r_out_ch      <= '0;
         r_y           <= '0;
         r_coef_wr_err <= 1'b0;
         r_sat_flag    <= 1'b0;
         for (int i = 0; i < NS; i++) begin
            r_w1[i] <= '0;
            r_w2[i] <= '0;
         end
         r_s     <= '0;
         r_w     <= '0;
         r_acc   <= '0;
         r_ch    <= '0;
         r_byp   <= 1'b0;
         r_sec   <= '0;
         r_step  <= '0;
         r_prime <= 1'b0;
      end else begin
         r_out_valid   <= 1'b0;
         r_coef_wr_err <= coef_we && w_coef_ok && (r_state != S_IDLE);
         if (w_sat_evt)    r_sat_flag <= 1'b1;
         else if (sat_clr) r_sat_flag <= 1'b0;

         unique case (r_state)
            S_IDLE: begin
               if (state_clr) begin
                  for (int i = 0; i < NS; i++) begin
                     r_w1[i] <= '0;
                     r_w2[i] <= '0;
                  end
               end
               if (in_valid) begin
                  r_s        <= x;
                  r_ch       <= ({1'b0, in_ch} < NCH_W) ? in_ch : '0;
                  r_byp      <= bypass;
                  r_sec      <= '0;
                  r_step     <= '0;
                  r_prime    <= 1'b1;
                  r_in_ready <= 1'b0;
                  r_state    <= S_MAC;
               end
            end
            S_MAC: begin
               if (r_prime) begin
                  r_prime <= 1'b0;
               end else begin
                  r_acc <= w_acc_next;
                  // Bypassed samples run the same schedule but leave state and data untouched.
                  if (!r_byp) begin
                     if (r_step == 3'd1) r_w <= w_res;
                     if (r_step == 3'd4) begin
                        r_s          <= w_res;
                        r_w2[w_sidx] <= r_w1[w_sidx];
                        r_w1[w_sidx] <= r_w;
                     end
                  end
                  if (r_step == 3'd4) begin
                     r_step <= '0;
                     if (r_sec == SW'(NSEC - 1)) r_state <= S_OUT;
                     else                        r_sec   <= r_sec + 1'b1;
                  end else begin
                     r_step <= r_step + 3'd1;
                  end
               end
            end
            S_OUT: begin
               r_y         <= r_s;
               r_out_ch    <= r_ch;
               r_out_valid <= 1'b1;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_ch      = r_out_ch;
   assign y           = r_y;
   assign coef_wr_err = r_coef_wr_err;
   assign sat_flag    = r_sat_flag;

endmodule

// File: tb/tb_iir_sos_tdm_filter.sv
// Directed bench for iir_sos_tdm_filter: stimulus pushes expected outputs,
// an independent monitor pops and compares on every out_valid.
module tb_iir_sos_tdm_filter;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [0:0]         in_ch = '0;
   logic signed [27:0] x = '0;
   logic               bypass = 1'b0;
   logic               out_valid;
   logic [0:0]         out_ch;
   logic signed [27:0] y;
   logic               coef_we = 1'b0;
   logic [3:0]         coef_addr = '0;
   logic signed [17:0] coef_wdata = '0;
   logic               coef_wr_err;
   logic               state_clr = 1'b0;
   logic               sat_flag;
   logic               sat_clr = 1'b0;

   typedef struct {
      int ch;
      int yv;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   iir_sos_tdm_filter dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .x(x), .bypass(bypass),
      .out_valid(out_valid), .out_ch(out_ch), .y(y),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_wr_err(coef_wr_err),
      .state_clr(state_clr), .sat_flag(sat_flag), .sat_clr(sat_clr)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endfunction

   // Monitor: one line per output transaction, compared against the queue head.
   always @(negedge clk) begin
      if (reset && out_valid) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got y=%0d ch=%0d, want no output", y, out_ch);
         end else begin
            exp_t e;
            e = q.pop_front();
            $display("out ch=%0d y=%0d (expect ch=%0d y=%0d)", out_ch, y, e.ch, e.yv);
            chk("y", longint'(y), longint'(e.yv));
            chk("out_ch", longint'(out_ch), longint'(e.ch));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      if (!out_valid) chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic send(input int ch, input int xv, input bit byp, input bit clr, input int exp_y);
      int  guard;
      int  lat;
      bit  ready_hi;
      exp_t e;
      guard = 0;
      while (!in_ready && guard < 100) begin
         step();
         guard++;
      end
      if (!in_ready) chk("ready_timeout", 0, 1);
      in_valid  = 1'b1;
      in_ch     = ch[0:0];
      x         = xv[27:0];
      bypass    = byp;
      state_clr = clr;
      e.ch = ch;
      e.yv = exp_y;
      q.push_back(e);
      step();
      in_valid  = 1'b0;
      bypass    = 1'b0;
      state_clr = 1'b0;
      lat = 0;
      ready_hi = 1'b0;
      while (!out_valid && lat < 40) begin
         if (in_ready) ready_hi = 1'b1;
         step();
         lat++;
      end
      chk("latency", lat, 17);
      chk("in_ready_low", ready_hi, 0);
   endtask

   task automatic wr_coef(input int addr, input int val, input bit exp_err);
      coef_we    = 1'b1;
      coef_addr  = addr[3:0];
      coef_wdata = val[17:0];
      step();
      coef_we = 1'b0;
      chk("coef_wr_err", coef_wr_err, exp_err);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      int seen;
      exp_t e;

      // Reset defaults
      step();
      step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y", longint'(y), 0);
      chk("rst_wr_err", coef_wr_err, 0);
      chk("rst_sat", sat_flag, 0);
      reset = 1'b1;
      step();

      // Pass-through with reset coefficients
      send(0, 819200, 0, 0, 819200);

      // a1 = -0.5 in section 0: impulse decays by halves; ch1 and a bypass sample interleaved
      wr_coef(3, -8192, 0);
      send(0, 8192, 0, 1, 8192);
      send(1, 0, 0, 0, 0);
      send(0, 555, 1, 0, 555);
      send(0, 0, 0, 0, 4096);
      send(1, 0, 0, 0, 0);
      send(0, 0, 0, 0, 2048);
      send(1, 0, 0, 0, 0);
      send(0, 0, 0, 0, 1024);
      chk("sat_quiet", sat_flag, 0);

      // Saturation with b0 ~ 2.0 in every section
      wr_coef(3, 0, 0);
      wr_coef(0, 32767, 0);
      wr_coef(5, 32767, 0);
      wr_coef(10, 32767, 0);
      send(0, 134217727, 0, 0, 134217727);
      chk("sat_set_pos", sat_flag, 1);
      sat_clr = 1'b1;
      step();
      sat_clr = 1'b0;
      chk("sat_clr_pos", sat_flag, 0);
      send(1, -134217728, 0, 0, -134217728);
      chk("sat_set_neg", sat_flag, 1);
      sat_clr = 1'b1;
      step();
      sat_clr = 1'b0;
      chk("sat_clr_neg", sat_flag, 0);
      send(0, 134217727, 1, 0, 134217727);
      chk("sat_bypass", sat_flag, 0);
      wr_coef(0, 16384, 0);
      wr_coef(5, 16384, 0);
      wr_coef(10, 16384, 0);

      // Coefficient write while busy is dropped
      in_valid = 1'b1;
      in_ch    = 1'b0;
      x        = 28'sd1234;
      e.ch = 0;
      e.yv = 1234;
      q.push_back(e);
      step();
      in_valid = 1'b0;
      step();
      step();
      wr_coef(0, 8192, 1);
      step();
      chk("wr_err_pulse", coef_wr_err, 0);
      wait_out("busy_sample");
      step();
      send(0, 1000, 0, 1, 1000);
      wr_coef(15, 0, 0);
      wr_coef(0, 8192, 0);
      send(0, 1000, 0, 1, 500);
      wr_coef(0, 16384, 0);

      // Reset in the middle of MAC aborts the sample and restores pass-through coefficients
      wr_coef(3, -8192, 0);
      in_valid = 1'b1;
      x        = 28'sd8192;
      step();
      in_valid = 1'b0;
      repeat (5) step();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_y", longint'(y), 0);
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         if (out_valid) seen++;
         step();
      end
      chk("abort_no_out", seen, 0);
      send(0, 8192, 0, 0, 8192);
      send(0, 0, 0, 0, 0);

      repeat (3) step();
      chk("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
